// File: rtl/mdu_hilo_pkg.sv
// Shared MDU definitions: operation codes, sequencer states and op-class helpers.
// Op classification depends on MDU_MADD_EN (accumulate ops are NONE when it is undefined).
package mdu_hilo_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8,
      MDU_MADD  = 4'd9,
      MDU_MADDU = 4'd10,
      MDU_MSUB  = 4'd11,
      MDU_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   localparam int CNT_W = 4;

   function automatic logic is_mul_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
             (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
      return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
   endfunction

   function automatic logic is_div_class(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_hilo_xfer(input logic [3:0] op);
      return (op == MDU_MFHI) || (op == MDU_MFLO) || (op == MDU_MTHI) || (op == MDU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator {hi,lo} for mult/div (and madd family).
// Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
   import mdu_hilo_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] res
);

   logic [63:0] w_sprod;
   logic [63:0] w_uprod;
   logic        w_bzero;
   logic [31:0] w_bden;
   logic [31:0] w_amag;
   logic [31:0] w_bmag;
   logic [31:0] w_uquo;
   logic [31:0] w_urem;
   logic [31:0] w_mquo;
   logic [31:0] w_mrem;
   logic [31:0] w_squo;
   logic [31:0] w_srem;

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign w_uprod = {32'd0, a} * {32'd0, b};

   assign w_bzero = (b == 32'd0);
   assign w_bden  = w_bzero ? 32'd1 : b;
   assign w_uquo  = a / w_bden;
   assign w_urem  = a % w_bden;

   // Signed division through magnitudes: truncation toward zero, remainder follows
   // the dividend, and 0x80000000 / -1 wraps to 0x80000000 without host-side overflow.
   assign w_amag = a[31] ? (~a + 32'd1) : a;
   assign w_bmag = w_bzero ? 32'd1 : (b[31] ? (~b + 32'd1) : b);
   assign w_mquo = w_amag / w_bmag;
   assign w_mrem = w_amag % w_bmag;
   assign w_squo = (a[31] ^ b[31]) ? (~w_mquo + 32'd1) : w_mquo;
   assign w_srem = a[31] ? (~w_mrem + 32'd1) : w_mrem;

`ifdef MDU_MADD_EN
   logic [63:0] w_acc;
   assign w_acc = {hi, lo};
`else
   logic w_unused_acc;
   assign w_unused_acc = ^{hi, lo};
`endif

   always_comb begin
      res = '0;
      case (op)
         MDU_MULT:  res = w_sprod;
         MDU_MULTU: res = w_uprod;
         MDU_DIV:   res = w_bzero ? {a, 32'hFFFF_FFFF} : {w_srem, w_squo};
         MDU_DIVU:  res = w_bzero ? {a, 32'hFFFF_FFFF} : {w_urem, w_uquo};
`ifdef MDU_MADD_EN
         MDU_MADD:  res = w_acc + w_sprod;
         MDU_MADDU: res = w_acc + w_uprod;
         MDU_MSUB:  res = w_acc - w_sprod;
         MDU_MSUBU: res = w_acc - w_uprod;
`endif
         default:   res = '0;
      endcase
   end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit: fixed-latency mult/div sequencing and HI/LO ownership.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (latency as mult).
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        HILObusy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] rd_data
);

   mdu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_thi;
   logic [31:0]      r_tlo;
   logic             r_busy;

   logic [63:0]      w_res;
   logic             w_is_mul;
   logic             w_is_div;

   mdu_arith u_arith (
      .op  (op),
      .a   (A),
      .b   (B),
      .hi  (r_hi),
      .lo  (r_lo),
      .res (w_res)
   );

   assign w_is_mul = is_mul_class(op);
   assign w_is_div = is_div_class(op);

   // The combinational term stalls a dependent instruction from the producer's first E cycle.
   assign HILObusy = (start & (w_is_mul | w_is_div)) | r_busy;
   assign HI       = r_hi;
   assign LO       = r_lo;
   assign rd_data  = (op == MDU_MFHI) ? r_hi : r_lo;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_thi   <= '0;
         r_tlo   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (w_is_mul) begin
                     r_thi   <= w_res[63:32];
                     r_tlo   <= w_res[31:0];
                     r_cnt   <= CNT_W'(MULT_CYCLES);
                     r_busy  <= 1'b1;
                     r_state <= ST_MUL;
                  end else if (w_is_div) begin
                     r_thi   <= w_res[63:32];
                     r_tlo   <= w_res[31:0];
                     r_cnt   <= CNT_W'(DIV_CYCLES);
                     r_busy  <= 1'b1;
                     r_state <= ST_DIV;
                  end else if (op == MDU_MTHI) begin
                     r_hi <= A;
                  end else if (op == MDU_MTLO) begin
                     r_lo <= A;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               // Result was captured at start; the counter only models the latency.
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_hi    <= r_thi;
                  r_lo    <= r_tlo;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset_n && start && (r_state != ST_IDLE))
         assert (!(w_is_mul || w_is_div || is_hilo_xfer(op)))
            else $warning("mdu_hilo: op %0d issued while busy is ignored", op);
   end
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed test-plan cases plus randomized traffic
// compared every cycle against a timestamp-based arithmetic reference model.
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic        start   = 1'b0;
   logic [3:0]  op      = 4'd0;
   logic [31:0] A       = '0;
   logic [31:0] B       = '0;
   logic        HILObusy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] rd_data;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .HILObusy (HILObusy),
      .HI       (HI),
      .LO       (LO),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   // Reference model: architectural HI/LO plus one pending result and the edge it lands on.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] m_pend = '0;
   bit          m_busy = 1'b0;
   longint      m_edge = 0;
   longint      m_commit_at = 0;

   function automatic bit md_mul(input logic [3:0] o);
`ifdef MDU_MADD_EN
      return o inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
      return o inside {MDU_MULT, MDU_MULTU};
`endif
   endfunction

   function automatic bit md_div(input logic [3:0] o);
      return o inside {MDU_DIV, MDU_DIVU};
   endfunction

   function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] a, b, hi, lo);
      longint          sp, q, r;
      longint unsigned ua, ub, up;
      sp = longint'($signed(a)) * longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      up = ua * ub;
      case (o)
         MDU_MULT:  return 64'(sp);
         MDU_MULTU: return 64'(up);
         MDU_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            return {r[31:0], q[31:0]};
         end
         MDU_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  return {hi, lo} + 64'(sp);
         MDU_MADDU: return {hi, lo} + 64'(up);
         MDU_MSUB:  return {hi, lo} - 64'(sp);
         MDU_MSUBU: return {hi, lo} - 64'(up);
`endif
         default:   return {hi, lo};
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_pend <= '0;
         m_busy <= 1'b0;
      end else begin
         m_edge <= m_edge + 1;
         if (m_busy) begin
            if (m_edge + 1 == m_commit_at) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_busy <= 1'b0;
            end
         end else if (start) begin
            if (md_mul(op) || md_div(op)) begin
               m_pend      <= model_result(op, A, B, m_hi, m_lo);
               m_busy      <= 1'b1;
               m_commit_at <= m_edge + 1 + longint'(md_div(op) ? DC : MC);
            end else if (op == MDU_MTHI) begin
               m_hi <= A;
            end else if (op == MDU_MTLO) begin
               m_lo <= A;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("HI", HI, m_hi);
         chk("LO", LO, m_lo);
         chk("HILObusy", 32'(HILObusy), 32'((start && (md_mul(op) || md_div(op))) || m_busy));
         chk("rd_data", rd_data, (op == MDU_MFHI) ? m_hi : m_lo);
      end
   end

   task automatic drive(input bit s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = s;
      op    = o;
      A     = a;
      B     = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_md(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el);
      drive(1'b1, o, a, b);
      #1;
      chk({name, "_busy_start"}, 32'(HILObusy), 32'd1);
      step();
      drive(1'b0, MDU_NONE, '0, '0);
      for (int i = 0; i < lat; i++) begin
         chk({name, "_busy"}, 32'(HILObusy), 32'd1);
         step();
      end
      chk({name, "_busy_end"}, 32'(HILObusy), 32'd0);
      chk({name, "_HI"}, HI, eh);
      chk({name, "_LO"}, LO, el);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         s;
      logic [3:0] o;

      #2 reset_n = 1'b0;
      #1 chk_en = 1'b1;
      chk("rst_HI", HI, 32'd0);
      chk("rst_LO", LO, 32'd0);
      chk("rst_busy", 32'(HILObusy), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      run_md("mult",  MDU_MULT,  32'hFFFF_FFFD, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_md("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, MC, 32'd1,         32'hFFFF_FFFE);
      run_md("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu",  MDU_DIVU,  32'd7,         32'd2, DC, 32'd1,         32'd3);
      run_md("div0",  MDU_DIV,   32'd9,         32'd0, DC, 32'd9,         32'hFFFF_FFFF);

      drive(1'b1, MDU_MTHI, 32'h1234, '0);
      #1 chk("mthi_busy", 32'(HILObusy), 32'd0);
      step();
      drive(1'b1, MDU_MFHI, '0, '0);
      #1;
      chk("mthi_HI", HI, 32'h1234);
      chk("mfhi_rd", rd_data, 32'h1234);
      chk("mfhi_busy", 32'(HILObusy), 32'd0);
      drive(1'b1, MDU_MFLO, '0, '0);
      #1 chk("mflo_rd", rd_data, 32'hFFFF_FFFF);
      step();
      drive(1'b1, MDU_MTLO, 32'hCAFE, '0);
      step();
      drive(1'b0, MDU_MFLO, '0, '0);
      #1;
      chk("mtlo_LO", LO, 32'hCAFE);
      chk("mtlo_rd", rd_data, 32'hCAFE);

      drive(1'b1, MDU_DIVU, 32'd100, 32'd3);
      step();
      drive(1'b0, MDU_NONE, '0, '0);
      repeat (3) step();
      #1 reset_n = 1'b0;
      #1;
      chk("abort_HI", HI, 32'd0);
      chk("abort_LO", LO, 32'd0);
      chk("abort_busy", 32'(HILObusy), 32'd0);
      step();
      reset_n = 1'b1;
      run_md("post_rst", MDU_MULT, 32'd2, 32'd3, MC, 32'd0, 32'd6);

      drive(1'b1, MDU_MULT, 32'd7, 32'd6);
      step();
      drive(1'b1, MDU_MULT, 32'd100, 32'd100);
      #1 chk("ign_busy", 32'(HILObusy), 32'd1);
      step();
      drive(1'b0, MDU_NONE, '0, '0);
      repeat (MC - 1) step();
      chk("ign_HI", HI, 32'd0);
      chk("ign_LO", LO, 32'd42);
      repeat (8) step();
      chk("ign_LO_hold", LO, 32'd42);

      for (int n = 0; n < 2500; n++) begin
         if (n % 500 == 250) begin
            reset_n = 1'b0;
            drive(1'b0, MDU_NONE, '0, '0);
            step();
            reset_n = 1'b1;
         end
         s = ($urandom_range(0, 3) != 0);
         if (m_busy) begin
            if ($urandom_range(0, 1) == 0) o = MDU_NONE;
            else o = 4'(12 + $urandom_range(1, 3));
         end else begin
            o = 4'($urandom_range(0, 15));
         end
         drive(s, o, rnd_operand(), rnd_operand());
         step();
      end

      drive(1'b0, MDU_NONE, '0, '0);
      repeat (DC + 2) step();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
